// File: rtl/score_disp_pkg.sv
// Shared definitions for the score display slice.
//   - conv_state_t : converter FSM encoding (IDLE / SHIFT / DONE)
//   - SEG_*        : active-low seven-segment codes, dp off, bits [6:0]=gfedcba
//   - BCD_W        : width of one BCD digit
//   - SAT_MAX_DEFAULT : largest value that fits on four decimal digits
//   - seg_encode() : BCD nibble to segment code; non-decimal nibbles show blank
package score_disp_pkg;

    localparam int BCD_W           = 4;
    localparam int SAT_MAX_DEFAULT = 9999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_encode(input logic [BCD_W-1:0] nib);
        logic [7:0] code;
        case (nib)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd16_seq.sv
// Sequential double-dabble converter, one bit per clock.
// Watches bin; whenever it differs from the last converted value, loads a
// saturated copy, runs 16 add-3/shift steps and then commits the result.
//   clk_main : clock, rising edge
//   rst      : asynchronous active-high reset
//   bin      : unsigned binary input
//   bcd      : committed BCD digits, {thousands, hundreds, tens, ones}
//   ovf      : committed value was saturated
//   busy     : high while in SHIFT or DONE
module bin2bcd16_seq
    import score_disp_pkg::*;
#(
    parameter int SAT_MAX = SAT_MAX_DEFAULT
) (
    input  logic        clk_main,
    input  logic        rst,
    input  logic [15:0] bin,
    output logic [15:0] bcd,
    output logic        ovf,
    output logic        busy
);

    localparam logic [15:0] SAT_VAL = 16'(SAT_MAX);

    conv_state_t state_reg, state_next;
    logic [15:0] last_reg, last_next;
    logic [15:0] bin_reg, bin_next;
    logic [15:0] work_reg, work_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        ovf_pend_reg, ovf_pend_next;
    logic [15:0] digits_reg, digits_next;
    logic        ovf_reg, ovf_next;

    logic [15:0] adj;
    logic        over;

    assign over = (bin > SAT_VAL);

    // Add-3 correction of every nibble that would overflow past 9 when doubled.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign adj[gi*BCD_W +: BCD_W] =
                (work_reg[gi*BCD_W +: BCD_W] >= 4'd5) ?
                work_reg[gi*BCD_W +: BCD_W] + 4'd3 :
                work_reg[gi*BCD_W +: BCD_W];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        bin_next      = bin_reg;
        work_next     = work_reg;
        cnt_next      = cnt_reg;
        ovf_pend_next = ovf_pend_reg;
        digits_next   = digits_reg;
        ovf_next      = ovf_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bin != last_reg) begin
                    last_next     = bin;
                    bin_next      = over ? SAT_VAL : bin;
                    ovf_pend_next = over;
                    work_next     = '0;
                    cnt_next      = '0;
                    state_next    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Correction and shift happen together; the bit shifted out
                // of the top BCD nibble is always zero since the value <= 9999.
                {work_next, bin_next} = {adj, bin_reg} << 1;
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == 4'd15) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                digits_next = work_reg;
                ovf_next    = ovf_pend_reg;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            last_reg     <= '0;
            bin_reg      <= '0;
            work_reg     <= '0;
            cnt_reg      <= '0;
            ovf_pend_reg <= 1'b0;
            digits_reg   <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            bin_reg      <= bin_next;
            work_reg     <= work_next;
            cnt_reg      <= cnt_next;
            ovf_pend_reg <= ovf_pend_next;
            digits_reg   <= digits_next;
            ovf_reg      <= ovf_next;
        end
    end

    assign bcd  = digits_reg;
    assign ovf  = ovf_reg;
    assign busy = (state_reg != ST_IDLE);

endmodule

// File: rtl/score_bcd_display.sv
// Score to 4-digit multiplexed seven-segment display.
// The converter turns the binary score into committed BCD digits; a
// free-running scanner walks the digit index and drives registered,
// active-low segment and anode outputs, with optional leading-zero blanking.
//   clk_main   : clock, rising edge
//   rst        : asynchronous active-high reset
//   score      : unsigned binary score
//   blank_lead : 1 = blank leading zero digits (ones digit always shown)
//   seg        : active-low segments, [6:0]=gfedcba, [7]=dp
//   an         : active-low digit enables, an[0] = ones
//   ovf        : displayed value is saturated
//   busy       : conversion in progress
module score_bcd_display
    import score_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int SAT_MAX  = SAT_MAX_DEFAULT
) (
    input  logic        clk_main,
    input  logic        rst,
    input  logic [15:0] score,
    input  logic        blank_lead,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        ovf,
    output logic        busy
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] bcd;

    bin2bcd16_seq #(
        .SAT_MAX(SAT_MAX)
    ) u_conv (
        .clk_main(clk_main),
        .rst     (rst),
        .bin     (score),
        .bcd     (bcd),
        .ovf     (ovf),
        .busy    (busy)
    );

    // zero_from[i]: digits i..3 are all zero, i.e. digit i is a leading zero.
    logic [3:1]  zero_from;
    logic [31:0] digit_seg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [BCD_W-1:0] nib;
            assign nib = bcd[gi*BCD_W +: BCD_W];
            if (gi == 0) begin : g_ones
                assign digit_seg[gi*8 +: 8] = seg_encode(nib);
            end else begin : g_upper
                if (gi == 3) begin : g_msd
                    assign zero_from[gi] = (nib == '0);
                end else begin : g_mid
                    assign zero_from[gi] = (nib == '0) && zero_from[gi+1];
                end
                assign digit_seg[gi*8 +: 8] =
                    (blank_lead && zero_from[gi]) ? SEG_BLANK : seg_encode(nib);
            end
        end
    endgenerate

    logic [15:0] div_reg, div_next;
    logic [1:0]  idx_reg, idx_next;
    logic [3:0]  an_reg, an_next;
    logic [7:0]  seg_reg, seg_next;

    // an/seg are recomputed every cycle from the current index, so they follow
    // an index change one cycle later and pick up new digits promptly.
    always_comb begin
        div_next = div_reg + 16'd1;
        idx_next = idx_reg;
        if (div_reg == DIV_LAST) begin
            div_next = '0;
            idx_next = idx_reg + 2'd1;
        end
        an_next  = 4'b1111 ^ (4'b0001 << idx_reg);
        seg_next = digit_seg[{idx_reg, 3'b000} +: 8];
    end

    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            div_reg <= '0;
            idx_reg <= '0;
            an_reg  <= 4'b1111;
            seg_reg <= SEG_BLANK;
        end else begin
            div_reg <= div_next;
            idx_reg <= idx_next;
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;

endmodule

// File: tb/tb_score_bcd_display.sv
module tb_score_bcd_display;
    import score_disp_pkg::*;

    logic        clk_main   = 1'b0;
    logic        rst        = 1'b1;
    logic [15:0] score      = 16'd0;
    logic        blank_lead = 1'b1;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        ovf;
    logic        busy;

    score_bcd_display #(
        .SCAN_DIV(4),
        .SAT_MAX (9999)
    ) dut (
        .clk_main  (clk_main),
        .rst       (rst),
        .score     (score),
        .blank_lead(blank_lead),
        .seg       (seg),
        .an        (an),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk_main = ~clk_main;

    int vec_count = 0;
    int err_count = 0;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
    } disp_exp_t;

    disp_exp_t sb_q[$];

    typedef struct {
        logic [15:0] score;
        logic        bl;
        logic [31:0] segs;   // {digit3, digit2, digit1, digit0}
        logic        ovf;
    } vec_t;

    vec_t vecs[10];
    logic [15:0] prev_score = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive a score; if it differs from the previous one, expect a conversion
    // lasting exactly 18 edges (busy high after edges 1..17, low after 18).
    task automatic apply(input logic [15:0] s, input logic bl);
        int cnt;
        score      = s;
        blank_lead = bl;
        if (s != prev_score) begin
            @(negedge clk_main);
            check("busy_start", {31'd0, busy}, 32'd1);
            cnt = 1;
            while (busy && cnt < 40) begin
                @(negedge clk_main);
                cnt++;
            end
            check("conv_latency", cnt, 32'd18);
        end else begin
            @(negedge clk_main);
            check("busy_idle", {31'd0, busy}, 32'd0);
        end
        prev_score = s;
    endtask

    // Wait for a fresh entry into the ones digit, then compare one full scan.
    task automatic check_display(input string name, input logic [31:0] segs);
        logic [3:0] prev_an;
        logic       found;
        disp_exp_t  e;
        found = 1'b0;
        for (int g = 0; g < 64 && !found; g++) begin
            prev_an = an;
            @(negedge clk_main);
            if (an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
        end
        check({name, "_scan_start"}, {31'd0, found}, 32'd1);
        if (!found) return;
        for (int k = 0; k < 4; k++) begin
            e.an  = 4'b1111 ^ (4'b0001 << k);
            e.seg = segs[k*8 +: 8];
            sb_q.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                prev_an = an;
                found   = 1'b0;
                for (int g = 0; g < 16 && !found; g++) begin
                    @(negedge clk_main);
                    if (an != prev_an) found = 1'b1;
                end
            end
            e = sb_q.pop_front();
            check({name, "_an"}, {28'd0, an}, {28'd0, e.an});
            check({name, "_seg"}, {24'd0, seg}, {24'd0, e.seg});
        end
    endtask

    initial begin
        disp_exp_t e;
        vecs[0] = '{16'd1234,  1'b1, 32'hF9A4B099, 1'b0};
        vecs[1] = '{16'd10000, 1'b1, 32'h90909090, 1'b1};
        vecs[2] = '{16'd50,    1'b1, 32'hFFFF92C0, 1'b0};
        vecs[3] = '{16'd7,     1'b0, 32'hC0C0C0F8, 1'b0};
        vecs[4] = '{16'd7,     1'b1, 32'hFFFFFFF8, 1'b0};
        vecs[5] = '{16'd1005,  1'b1, 32'hF9C0C092, 1'b0};
        vecs[6] = '{16'd9999,  1'b1, 32'h90909090, 1'b0};
        vecs[7] = '{16'd10,    1'b1, 32'hFFFFF9C0, 1'b0};
        vecs[8] = '{16'd0,     1'b0, 32'hC0C0C0C0, 1'b0};
        vecs[9] = '{16'd65535, 1'b1, 32'h90909090, 1'b1};

        // Reset state
        repeat (2) @(negedge clk_main);
        check("rst_an",   {28'd0, an},   32'hF);
        check("rst_seg",  {24'd0, seg},  32'hFF);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovf",  {31'd0, ovf},  32'd0);
        $display("reset: an=%b seg=%h busy=%b ovf=%b", an, seg, busy, ovf);

        // Release: score 0 needs no conversion; digit index advances every 4 clocks
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            e.an  = 4'b1111 ^ (4'b0001 << (c / 4));
            e.seg = (c / 4 == 0) ? SEG_0 : SEG_BLANK;
            sb_q.push_back(e);
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_main);
            e = sb_q.pop_front();
            check("scan_an",  {28'd0, an},  {28'd0, e.an});
            check("scan_seg", {24'd0, seg}, {24'd0, e.seg});
        end
        check("scan_busy", {31'd0, busy}, 32'd0);
        $display("scan after reset: 16 cycles checked");

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].score, vecs[i].bl);
            check("ovf", {31'd0, ovf}, {31'd0, vecs[i].ovf});
            check_display("disp", vecs[i].segs);
            $display("vec %0d: score=%0d blank_lead=%b ovf=%b", i, vecs[i].score, vecs[i].bl, ovf);
        end

        // Score changes mid-conversion: 100 then 200 at edge 5
        score      = 16'd100;
        blank_lead = 1'b1;
        repeat (4) @(negedge clk_main);
        score = 16'd200;
        repeat (13) @(negedge clk_main);
        check("chg_busy_e17", {31'd0, busy}, 32'd1);
        @(negedge clk_main);
        check("chg_idle_e18", {31'd0, busy}, 32'd0);
        for (int ed = 19; ed <= 36; ed++) begin
            @(negedge clk_main);
            if (ed == 19) check("chg_reload_e19", {31'd0, busy}, 32'd1);
            if (ed == 35) check("chg_busy_e35",   {31'd0, busy}, 32'd1);
            if (ed == 36) check("chg_idle_e36",   {31'd0, busy}, 32'd0);
            if (an == 4'b1011) check("chg_mid_digit2", {24'd0, seg}, {24'd0, SEG_1});
        end
        check_display("chg", 32'hFFA4C0C0);
        prev_score = 16'd200;
        $display("seq change: 100 -> 200 mid-conversion, shows 200");

        // Reset mid-conversion, then reconversion of 65535
        score = 16'd65535;
        repeat (8) @(negedge clk_main);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_an",   {28'd0, an},   32'hF);
        check("abort_seg",  {24'd0, seg},  32'hFF);
        check("abort_ovf",  {31'd0, ovf},  32'd0);
        @(negedge clk_main);
        check("abort_hold_an", {28'd0, an}, 32'hF);
        @(negedge clk_main);
        rst = 1'b0;
        repeat (17) @(negedge clk_main);
        check("reconv_busy_e17", {31'd0, busy}, 32'd1);
        check("reconv_ovf_e17",  {31'd0, ovf},  32'd0);
        @(negedge clk_main);
        check("reconv_busy_e18", {31'd0, busy}, 32'd0);
        check("reconv_ovf_e18",  {31'd0, ovf},  32'd1);
        check_display("reconv", 32'h90909090);
        $display("seq reset abort: 65535 reconverted, ovf=%b", ovf);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
